// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of a shared memory port and ALU.
// Optional performance counters (cyc_cnt, instr_cnt) are built when MC_CTRL_PERF_EN is defined.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on mem_ready
// DECODE | latch opcode, precompute branch target, jump or flag illegal
// EXEC   | ALU operation for R-type/addi/address calc/beq compare
// MEM    | data memory read (lw) or write (sw), held until mem_ready
// WB     | register file write from ALU out or memory data
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_cond_write,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        memRead_sel,
    output logic        MemWrite_sel,
    output logic        regDst_sel,
    output logic        MemtoReg_sel,
    output logic        RegWrite_sel,
    output logic        alu_srcA,
    output logic [1:0]  alu_srcB,
    output logic [1:0]  ALU_op,
`ifdef MC_CTRL_PERF_EN
    output logic [31:0] cyc_cnt,
    output logic [31:0] instr_cnt,
`endif
    output logic        illegal_op,
    output logic [2:0]  state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q;
    logic       op_legal;
    logic       to_fetch_legal;

    assign state = state_q;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal || opcode == OP_J) state_d = S_FETCH;
                else                             state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ:       state_d = S_FETCH;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // DECODE uses the live opcode because op_q only captures it at the end of that cycle.
    // Write strobes are suppressed under reset so an interrupted access leaves no side effect.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_cond_write = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        memRead_sel   = 1'b0;
        MemWrite_sel  = 1'b0;
        regDst_sel    = 1'b0;
        MemtoReg_sel  = 1'b0;
        RegWrite_sel  = 1'b0;
        alu_srcA      = 1'b0;
        alu_srcB      = 2'b00;
        ALU_op        = 2'b00;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead_sel = 1'b1;
                alu_srcB    = 2'b01;
                ir_write    = mem_ready && !rst;
                pc_write    = mem_ready && !rst;
            end
            S_DECODE: begin
                alu_srcB = 2'b10;
                if (!op_legal) begin
                    illegal_op = !rst;
                end else if (opcode == OP_J) begin
                    pc_write = !rst;
                    pc_src   = 2'b01;
                end
            end
            S_EXEC: begin
                alu_srcA = 1'b1;
                case (op_q)
                    OP_RTYPE: ALU_op = 2'b10;
                    OP_BEQ: begin
                        ALU_op        = 2'b01;
                        pc_cond_write = !rst;
                    end
                    default: alu_srcB = 2'b10;
                endcase
            end
            S_MEM: begin
                iord = 1'b1;
                if (op_q == OP_LW) memRead_sel  = 1'b1;
                else               MemWrite_sel = !rst;
            end
            S_WB: begin
                RegWrite_sel = !rst;
                regDst_sel   = (op_q == OP_RTYPE);
                MemtoReg_sel = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    always_comb begin
        to_fetch_legal = 1'b0;
        case (state_q)
            S_DECODE: to_fetch_legal = (opcode == OP_J);
            S_EXEC:   to_fetch_legal = (op_q == OP_BEQ);
            S_MEM:    to_fetch_legal = mem_ready && (op_q == OP_SW);
            S_WB:     to_fetch_legal = 1'b1;
            default:  to_fetch_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (to_fetch_legal)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`else
    assign to_fetch_legal = 1'b0;
`endif

endmodule
